// File: rtl/afifo_pkg.sv
// Shared definitions for the AFIFO read-side drain: FSM state encoding,
// default data width and the legal AFIFO read-latency settings.
package afifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_t;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned RD_LAT_MIN = 0;
  localparam int unsigned RD_LAT_MAX = 1;

  // True when the AFIFO read latency is one the drain knows how to track
  function automatic logic rd_lat_legal(input int unsigned lat);
    return (lat == RD_LAT_MIN) || (lat == RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/afifo_rd_buf.sv
// Small circular output buffer for the AFIFO drain: push, pop and occupancy.
// The head entry comes straight from the storage registers.
module afifo_rd_buf
  import afifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic [DATA_W-1:0]            rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              do_pop;

  // Pops on an empty buffer are ignored
  assign do_pop = pop && (occ != '0);

  // Wrap-around pointer increment for a non-power-of-two depth
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage write, pointer advance and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= ptr_inc(wptr);
      end
      if (do_pop) begin
        rptr <= ptr_inc(rptr);
      end
      if (push && !do_pop) begin
        occ <= occ + OCC_W'(1);
      end else if (!push && do_pop) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

  assign rdata = mem[rptr];

  // The credit rule upstream must never let a push land on a full buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && (occ == OCC_W'(DEPTH))));

endmodule

// File: rtl/afifo_rd_drain.sv
// Read-side consumer for the AFIFO read port (rclk domain). Pops words with
// credit-based prefetch, buffers them, and presents a valid/ready stream.
// Optional statistics counters are enabled with `define AFIFO_RD_STATS_EN.
module afifo_rd_drain
  import afifo_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned FIFO_RD_LAT = 0
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              empty,
  input  logic [DATA_W-1:0] readData,
  output logic              rinc,
  input  logic              en,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
`ifdef AFIFO_RD_STATS_EN
  ,
  output logic [31:0]       word_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned BUF_DEPTH = FIFO_RD_LAT + 2;
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CRD_W     = OCC_W + 1;

  rd_state_t         state;
  rd_state_t         state_nx;
  logic [OCC_W-1:0]  occ;
  logic              inflight;
  logic              push;
  logic              pop;
  logic [CRD_W-1:0]  pending;
  logic              credit_ok;

  // A read is allowed only while a buffer slot is reserved for its data
  assign pending   = CRD_W'(occ) + CRD_W'(inflight);
  assign credit_ok = pending < CRD_W'(BUF_DEPTH);
  assign rinc      = !rrst && (state == RUN) && !empty && credit_ok;

  // Track reads whose data has not yet reached the buffer
  if (FIFO_RD_LAT == 0) begin : g_lat0
    assign inflight = 1'b0;
    assign push     = rinc;
  end else begin : g_lat1
    logic rd_pipe;

    // One-edge delay between rinc and readData becoming valid
    always_ff @(posedge rclk) begin
      if (rrst) begin
        rd_pipe <= 1'b0;
      end else begin
        rd_pipe <= rinc;
      end
    end

    assign inflight = rd_pipe;
    assign push     = rd_pipe;
  end

  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != '0);

  afifo_rd_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk   (rclk),
    .rst   (rrst),
    .push  (push),
    .wdata (readData),
    .pop   (pop),
    .occ   (occ),
    .rdata (out_data)
  );

  // State register and registered busy flag
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  // Next-state: STOP holds until every issued read has been delivered
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (en) state_nx = RUN;
      end
      RUN: begin
        if (!en) state_nx = STOP;
      end
      STOP: begin
        if (en) begin
          state_nx = RUN;
        end else if (!inflight && (occ == '0)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef AFIFO_RD_STATS_EN
  // Saturating delivered-word and downstream-stall counters
  always_ff @(posedge rclk) begin
    if (rrst) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && out_ready && (word_cnt != '1)) begin
        word_cnt <= word_cnt + 32'd1;
      end
      if (out_valid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

  // Only read latencies of zero or one cycle are supported
  a_lat_legal: assert property (@(posedge rclk) rd_lat_legal(FIFO_RD_LAT));

endmodule
